dds_wave_multi: RTL

//  Multi-channel phase-accumulator (DDS) waveform generator driving external lookup ROM(s) and a DAC.

---
 rtl/dds_wave_multi.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dds_wave_multi.sv
// Multi-channel DDS phase-accumulator generator: per-channel tuning word, phase offset and
// waveform select feeding external ROM(s); ROM samples are passed straight through to the DAC.
module dds_wave_multi #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned WSEL_W  = 1,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROM_LAT = 1,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned RA_W   = WSEL_W + ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       sync,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [ACC_W-1:0]           cfg_ftw,
  input  logic [ACC_W-1:0]           cfg_phase,
  input  logic [WSEL_W-1:0]          cfg_wave,
  output logic [NUM_CH*RA_W-1:0]     rom_addr,
  input  logic [NUM_CH*DATA_W-1:0]   rom_data,
  output logic                       da_clk,
  output logic [NUM_CH*DATA_W-1:0]   da_data,
  output logic                       da_valid,
  output logic [NUM_CH-1:0]          wrap
);

  logic [ACC_W-1:0]        acc_q   [NUM_CH];
  logic [ACC_W-1:0]        acc_d   [NUM_CH];
  logic [ACC_W-1:0]        ftw_q   [NUM_CH];
  logic [ACC_W-1:0]        ftw_d   [NUM_CH];
  logic [ACC_W-1:0]        phase_q [NUM_CH];
  logic [ACC_W-1:0]        phase_d [NUM_CH];
  logic [WSEL_W-1:0]       wave_q  [NUM_CH];
  logic [WSEL_W-1:0]       wave_d  [NUM_CH];
  logic [ACC_W:0]          sum     [NUM_CH];
  logic [NUM_CH-1:0]       wrap_q, wrap_d;
  logic [NUM_CH*RA_W-1:0]  rom_addr_q, rom_addr_d;
  logic                    pend_q, pend_d;
  logic                    ready_q, ready_d;
  logic [CH_W-1:0]         sh_ch_q, sh_ch_d;
  logic [ACC_W-1:0]        sh_ftw_q, sh_ftw_d;
  logic [ACC_W-1:0]        sh_phase_q, sh_phase_d;
  logic [WSEL_W-1:0]       sh_wave_q, sh_wave_d;
  logic [ROM_LAT:0]        vld_q, vld_d;
  logic                    hit;

  always_comb begin
    acc_d      = acc_q;
    ftw_d      = ftw_q;
    phase_d    = phase_q;
    wave_d     = wave_q;
    wrap_d     = '0;
    rom_addr_d = '0;
    pend_d     = pend_q;
    sh_ch_d    = sh_ch_q;
    sh_ftw_d   = sh_ftw_q;
    sh_phase_d = sh_phase_q;
    sh_wave_d  = sh_wave_q;
    hit        = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sum[c] = {1'b0, acc_q[c]} + {1'b0, ftw_q[c]};
      if (sync) begin
        acc_d[c] = '0;
      end else if (en) begin
        acc_d[c]  = sum[c][ACC_W-1:0];
        wrap_d[c] = sum[c][ACC_W];
      end
      rom_addr_d[c*RA_W +: RA_W] =
        {wave_q[c], ADDR_W'((acc_q[c] + phase_q[c]) >> (ACC_W - ADDR_W))};
      // Pending config lands on the carry edge so the waveform stays phase-continuous;
      // a stalled or stopped accumulator never carries, so it takes the config at once.
      if (pend_q && sh_ch_q == CH_W'(c)) begin
        hit = 1'b1;
        if (sync || !en || ftw_q[c] == '0 || sum[c][ACC_W]) begin
          ftw_d[c]   = sh_ftw_q;
          phase_d[c] = sh_phase_q;
          wave_d[c]  = sh_wave_q;
          pend_d     = 1'b0;
        end
      end
    end
    // A request for a non-existent channel is dropped rather than blocking the shadow.
    if (pend_q && !hit) pend_d = 1'b0;
    if (!pend_q && cfg_valid) begin
      pend_d     = 1'b1;
      sh_ch_d    = cfg_ch;
      sh_ftw_d   = cfg_ftw;
      sh_phase_d = cfg_phase;
      sh_wave_d  = cfg_wave;
    end
    ready_d = !pend_d;
    vld_d   = {vld_q[ROM_LAT-1:0], en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c]   <= '0;
        ftw_q[c]   <= '0;
        phase_q[c] <= '0;
        wave_q[c]  <= '0;
      end
      wrap_q     <= '0;
      rom_addr_q <= '0;
      pend_q     <= 1'b0;
      ready_q    <= 1'b1;
      sh_ch_q    <= '0;
      sh_ftw_q   <= '0;
      sh_phase_q <= '0;
      sh_wave_q  <= '0;
      vld_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      ftw_q      <= ftw_d;
      phase_q    <= phase_d;
      wave_q     <= wave_d;
      wrap_q     <= wrap_d;
      rom_addr_q <= rom_addr_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      sh_ch_q    <= sh_ch_d;
      sh_ftw_q   <= sh_ftw_d;
      sh_phase_q <= sh_phase_d;
      sh_wave_q  <= sh_wave_d;
      vld_q      <= vld_d;
    end
  end

  assign cfg_ready = ready_q;
  assign rom_addr  = rom_addr_q;
  assign wrap      = wrap_q;
  assign da_valid  = vld_q[ROM_LAT];
  assign da_data   = rom_data;
  assign da_clk    = ~clk;

endmodule
